// File: rtl/tfe_pkg.sv
// Shared types and header layout for the TensorFlowE command sequencer.
package tfe_pkg;

   // Header opcode field values
   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_ACCUM = 2'b01,
      OP_READ  = 2'b10,
      OP_CLEAR = 2'b11
   } opcode_e;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      ACCUM     = 3'd2,
      READ      = 3'd3,
      READ_WAIT = 3'd4,
      CLEAR     = 3'd5
   } state_e;

   // Header byte layout: [7:6] opcode, [5:0] length minus one
   localparam int HDR_OPC_MSB = 7;
   localparam int HDR_OPC_LSB = 6;
   localparam int HDR_LEN_MSB = 5;
   localparam int HDR_LEN_LSB = 0;

   // Used to size the shared length/timeout counter
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tfe_cmd_sequencer.sv
// Host byte-stream parser that sequences write/read/clear/accumulate
// strobes into the TensorFlowE core and watches for read completion.
module tfe_cmd_sequencer
   import tfe_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int LEN_W          = 6,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] core_data,
   output logic              core_wr,
   output logic              core_read,
   output logic              core_clear,
   output logic              core_accu_en,
   input  logic              core_ena_out,
   output logic              busy,
   output logic              err
);

   // One counter serves both the packet length and the read timeout
   localparam int CNT_W = max_int(LEN_W + 1, $clog2(TIMEOUT_CYCLES + 1));

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_dec;
   logic [CNT_W-1:0] n_val;
   logic [CNT_W-1:0] timeout_val;
   logic             accept;
   logic             cnt_last;
   opcode_e          hdr_op;

   // Bytes are taken only while parsing headers or streaming LOAD operands
   assign in_ready    = rst_n && ((state == IDLE) || (state == LOAD));
   assign accept      = in_valid && in_ready;
   assign hdr_op      = opcode_e'(in_data[HDR_OPC_MSB:HDR_OPC_LSB]);
   assign n_val       = CNT_W'(in_data[HDR_LEN_LSB +: LEN_W]) + CNT_W'(1);
   assign timeout_val = CNT_W'(TIMEOUT_CYCLES);
   // Saturating decrement: the counter never wraps below zero
   assign cnt_dec     = (cnt == '0) ? '0 : (cnt - CNT_W'(1));
   // True on the cycle whose decrement takes the counter to zero
   assign cnt_last    = (cnt <= CNT_W'(1));

   // Packet FSM with all core-facing outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         core_data    <= '0;
         core_wr      <= 1'b0;
         core_read    <= 1'b0;
         core_clear   <= 1'b0;
         core_accu_en <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
      end else begin
         core_wr    <= 1'b0;
         core_read  <= 1'b0;
         core_clear <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  busy <= 1'b1;
                  case (hdr_op)
                     OP_LOAD: begin
                        state <= LOAD;
                        cnt   <= n_val;
                     end
                     OP_ACCUM: begin
                        state        <= ACCUM;
                        cnt          <= n_val;
                        core_accu_en <= 1'b1;
                     end
                     OP_READ: begin
                        state     <= READ;
                        cnt       <= timeout_val;
                        core_read <= 1'b1;
                     end
                     default: begin
                        state      <= CLEAR;
                        core_clear <= 1'b1;
                     end
                  endcase
               end
            end
            LOAD: begin
               if (accept) begin
                  core_data <= in_data;
                  core_wr   <= 1'b1;
                  cnt       <= cnt_dec;
                  if (cnt_last) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            ACCUM: begin
               cnt <= cnt_dec;
               if (cnt_last) begin
                  core_accu_en <= 1'b0;
                  state        <= IDLE;
                  busy         <= 1'b0;
               end
            end
            READ: begin
               state <= READ_WAIT;
            end
            READ_WAIT: begin
               // Completion takes priority over a coincident timeout
               if (core_ena_out) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt_dec;
                  if (cnt_last) begin
                     err   <= 1'b1;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            CLEAR: begin
               err   <= 1'b0;
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               busy         <= 1'b0;
               core_accu_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
